sr_imem_latency_responder: RTL

SR_IMEM_LATENCY_RESPONDER -- requirements
Module: sr_imem_latency_responder

---
 rtl/sr_imem_latency_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sr_imem_latency_responder.sv
// ============================================================================
// sr_imem_latency_responder - fixed-latency instruction memory with an in-order
// response FIFO. Optional macro: SR_IMEM_RANDOM_STALL_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sr_imem_latency_responder #(
  parameter int DEPTH_LOG2      = 6,
  parameter int LATENCY         = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int c_depth = 1 << DEPTH_LOG2;
  localparam int c_cw    = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_pw    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_cw-1:0] c_max_cnt  = c_cw'(MAX_OUTSTANDING);
  localparam logic [c_pw-1:0] c_last_ptr = c_pw'(MAX_OUTSTANDING - 1);

  logic [31:0]       r_mem [c_depth];
  logic [LATENCY-1:0] r_dv;
  logic [31:0]       r_dd [LATENCY];
  logic [31:0]       r_fifo [MAX_OUTSTANDING];
  logic [c_pw-1:0]   r_wptr;
  logic [c_pw-1:0]   r_rptr;
  logic [c_cw-1:0]   r_fcnt;
  logic [c_cw-1:0]   r_cnt;

  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic [31:0]       w_rd_word;
  logic              w_unused_addr;

  assign w_unused_addr = ^{req_addr[31:DEPTH_LOG2], ld_addr[31:DEPTH_LOG2]};

  assign w_accept     = req_valid && req_ready;
  assign w_pop        = rsp_valid && rsp_ready;
  assign w_fifo_empty = (r_fcnt == '0);
  assign w_rd_word    = r_mem[req_addr[DEPTH_LOG2-1:0]];

  // The last delay stage bypasses an empty FIFO so the first response is
  // visible exactly LATENCY cycles after acceptance; it is only buffered
  // when the consumer does not take it straight away.
  assign w_fifo_wr = r_dv[LATENCY-1] && !(w_fifo_empty && rsp_ready);
  assign w_fifo_rd = !w_fifo_empty && rsp_ready;

  assign rsp_valid = !w_fifo_empty || r_dv[LATENCY-1];
  assign rsp_data  = !rsp_valid    ? 32'h0 :
                     w_fifo_empty  ? r_dd[LATENCY-1] : r_fifo[r_rptr];

  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr[DEPTH_LOG2-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    r_dd[0] <= w_rd_word;
    for (int i = 1; i < LATENCY; i++) begin
      r_dd[i] <= r_dd[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dv <= '0;
    end else begin
      r_dv[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_dv[i] <= r_dv[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fifo_wr) begin
      r_fifo[r_wptr] <= r_dd[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + c_pw'(1);
      end
      if (w_fifo_rd) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + c_pw'(1);
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_fcnt <= r_fcnt + c_cw'(1);
        2'b01:   r_fcnt <= r_fcnt - c_cw'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Counts every request from acceptance until pop, so delay line plus FIFO
  // occupancy can never exceed MAX_OUTSTANDING.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cw'(1);
        2'b01:   r_cnt <= r_cnt - c_cw'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef SR_IMEM_RANDOM_STALL_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign req_ready = rst && (r_cnt < c_max_cnt) && !r_lfsr[0];
`else
  assign req_ready = rst && (r_cnt < c_max_cnt);
`endif

endmodule

`default_nettype wire
